// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command issuer and its response FIFO.
//   - ALU select codes driven onto the ALU sl bus
//   - branch condition codes (used only when ALU_ISSUER_BRANCH_EN is defined)
//   - default datapath width
//   - helper to classify illegal ALU selects
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH_DEF = 32;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_NE   = 2'b10;
   localparam logic [1:0] BR_ILL  = 2'b11;

   // Any select with the top bit set has no ALU meaning and must never
   // reach the ALU.
   function automatic logic op_is_illegal(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// ---------------------------------------------------------------------------
// alu_rsp_fifo
// Synchronous FIFO holding captured ALU responses until the consumer takes
// them. Same-cycle push and pop keep the count unchanged and preserve order.
// A pop while empty is ignored.
//
// Parameters:
//   DW    - entry width in bits
//   DEPTH - number of entries (power of two, >= 2)
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (empties the FIFO)
//   push      in   write push_data this cycle
//   push_data in   entry to write
//   pop       in   discard the head entry this cycle
//   head      out  entry at the head of the FIFO
//   count     out  number of valid entries (0..DEPTH)
//   empty     out  count == 0
// ---------------------------------------------------------------------------
module alu_rsp_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [DW-1:0]            head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      empty   = (count == '0);
      full    = (count == CW'(DEPTH));
      do_pop  = pop && !empty;
      do_push = push && !full;
      head    = mem[rd_ptr];
   end

   // Storage needs no reset: entries are only visible once count says so.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH; the count is kept separately so that
   // full and empty are distinguishable without a spare pointer bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // The issuer's admission rule must make a push into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
// Front end between the multicycle sequencer and the combinational 32-bit
// ALU. Commands arrive over a valid/ready handshake, are registered onto the
// ALU input bus for one cycle, and the ALU result is captured at the end of
// that cycle into a response FIFO that returns tagged results over a second
// valid/ready handshake.
//
// Optional feature (macro ALU_ISSUER_BRANCH_EN): adds cmd_br and rsp_taken,
// evaluating BEQ/BNE from the captured zero flag.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op, cmd_a, cmd_b       ALU select and operands
//   cmd_tag                    requester tag echoed in the response
//   cmd_br   (optional)        branch condition 00 none/01 BEQ/10 BNE/11 illegal
//   alu_sl, alu_a, alu_b       registered drive to the ALU
//   alu_out, alu_zero          ALU result and zero flag
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_zero       captured result and zero flag
//   rsp_err, rsp_tag           illegal-command flag, command tag
//   rsp_taken (optional)       branch taken
//   busy                       issue stage occupied or FIFO non-empty
// ---------------------------------------------------------------------------
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int WIDTH     = ALU_WIDTH_DEF,
   parameter int TAG_W     = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
`ifdef ALU_ISSUER_BRANCH_EN
   input  logic [1:0]       cmd_br,
   output logic             rsp_taken,
`endif
   output logic [2:0]       alu_sl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);

   localparam int CW  = $clog2(RSP_DEPTH) + 1;
   localparam int CW1 = CW + 1;
`ifdef ALU_ISSUER_BRANCH_EN
   localparam int EW  = WIDTH + TAG_W + 3;
`else
   localparam int EW  = WIDTH + TAG_W + 2;
`endif

   logic             issue_v;
   logic [TAG_W-1:0] issue_tag;
   logic             issue_err;
   logic             accept;
   logic             cmd_err;
   logic [CW1-1:0]   occupancy;
   logic [WIDTH-1:0] cap_result;
   logic             cap_zero;
   logic [EW-1:0]    push_data;
   logic [EW-1:0]    head;
   logic [CW-1:0]    fifo_count;
   logic             fifo_empty;
   logic [WIDTH-1:0] head_result;
   logic             head_zero;
   logic             head_err;
   logic [TAG_W-1:0] head_tag;
`ifdef ALU_ISSUER_BRANCH_EN
   logic [1:0]       issue_br;
   logic             cap_taken;
   logic             head_taken;
`endif

   // Admission counts the slot in the issue stage as already owning a FIFO
   // entry, so a command is only taken when its response is guaranteed room.
   // Depends on registered state only.
   always_comb begin
      occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, issue_v};
      cmd_ready = (occupancy < CW1'(RSP_DEPTH));
      accept    = cmd_valid && cmd_ready;
`ifdef ALU_ISSUER_BRANCH_EN
      cmd_err   = op_is_illegal(cmd_op) || (cmd_br == BR_ILL);
`else
      cmd_err   = op_is_illegal(cmd_op);
`endif
   end

   // Issue stage. The ALU bus only changes on an accept so the ALU inputs do
   // not toggle while idle; an illegal select is replaced by add so that 1xx
   // never reaches the ALU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_v   <= 1'b0;
         alu_sl    <= ALU_ADD;
         alu_a     <= '0;
         alu_b     <= '0;
         issue_tag <= '0;
         issue_err <= 1'b0;
`ifdef ALU_ISSUER_BRANCH_EN
         issue_br  <= BR_NONE;
`endif
      end else begin
         issue_v <= accept;
         if (accept) begin
            alu_sl    <= op_is_illegal(cmd_op) ? ALU_ADD : cmd_op;
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            issue_tag <= cmd_tag;
            issue_err <= cmd_err;
`ifdef ALU_ISSUER_BRANCH_EN
            issue_br  <= cmd_br;
`endif
         end
      end
   end

   // Capture formatting: an erroneous slot reports result 0, zero 0 and no
   // branch, regardless of what the ALU computed for the substituted add.
   always_comb begin
      cap_result = alu_out;
      cap_zero   = alu_zero;
      if (issue_err) begin
         cap_result = '0;
         cap_zero   = 1'b0;
      end
`ifdef ALU_ISSUER_BRANCH_EN
      cap_taken = 1'b0;
      if (!issue_err) begin
         case (issue_br)
            BR_EQ:   cap_taken = alu_zero;
            BR_NE:   cap_taken = !alu_zero;
            default: cap_taken = 1'b0;
         endcase
      end
      push_data = {cap_taken, cap_result, cap_zero, issue_err, issue_tag};
`else
      push_data = {cap_result, cap_zero, issue_err, issue_tag};
`endif
   end

   alu_rsp_fifo #(
      .DW    (EW),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (issue_v),
      .push_data (push_data),
      .pop       (rsp_valid && rsp_ready),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   // Response outputs are forced to zero while the FIFO is empty so that
   // stale storage contents never appear on the bus.
   always_comb begin
`ifdef ALU_ISSUER_BRANCH_EN
      {head_taken, head_result, head_zero, head_err, head_tag} = head;
      rsp_taken  = !fifo_empty && head_taken;
`else
      {head_result, head_zero, head_err, head_tag} = head;
`endif
      rsp_valid  = !fifo_empty;
      rsp_result = fifo_empty ? '0 : head_result;
      rsp_zero   = !fifo_empty && head_zero;
      rsp_err    = !fifo_empty && head_err;
      rsp_tag    = fifo_empty ? '0 : head_tag;
      busy       = issue_v || !fifo_empty;
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
// Self-checking bench for alu_cmd_issuer. A behavioural ALU closes the loop
// from alu_sl/alu_a/alu_b to alu_out/alu_zero. Every accepted command is
// turned into an expected response by an arithmetic model and queued; every
// response handshake is compared against the queue head.
// Build with +define+ALU_ISSUER_BRANCH_EN to exercise the branch feature.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;

   localparam int WIDTH = 32;
   localparam int TAG_W = 4;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [TAG_W-1:0] cmd_tag;
   logic [1:0]       cmd_br;
   logic [2:0]       alu_sl;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_out;
   logic             alu_zero;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_err;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;
`ifdef ALU_ISSUER_BRANCH_EN
   logic             rsp_taken;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             err;
      logic             taken;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   alu_cmd_issuer #(
      .WIDTH     (WIDTH),
      .TAG_W     (TAG_W),
      .RSP_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_tag    (cmd_tag),
`ifdef ALU_ISSUER_BRANCH_EN
      .cmd_br     (cmd_br),
      .rsp_taken  (rsp_taken),
`endif
      .alu_sl     (alu_sl),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_out    (alu_out),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .rsp_tag    (rsp_tag),
      .busy       (busy)
   );

   // Behavioural combinational ALU; 1xx yields a poison value.
   always_comb begin
      case (alu_sl)
         3'b000:  alu_out = alu_a + alu_b;
         3'b001:  alu_out = alu_a - alu_b;
         3'b010:  alu_out = ((alu_a != 0) && (alu_b != 0)) ? 32'd1 : 32'd0;
         3'b011:  alu_out = ((alu_a != 0) || (alu_b != 0)) ? 32'd1 : 32'd0;
         default: alu_out = 32'hDEAD_BEEF;
      endcase
      alu_zero = (alu_out == 0);
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Expected response computed directly from the command.
   function automatic exp_t modelResponse(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                                          input logic [1:0] br);
      exp_t e;
      e.tag   = tag;
      e.err   = op[2] || (br == 2'b11);
      e.taken = 1'b0;
      if (e.err) begin
         e.result = 0;
         e.zero   = 1'b0;
      end else begin
         case (op[1:0])
            2'd0:    e.result = a + b;
            2'd1:    e.result = a - b;
            2'd2:    e.result = ((a != 0) && (b != 0)) ? 1 : 0;
            default: e.result = ((a != 0) || (b != 0)) ? 1 : 0;
         endcase
         e.zero = (e.result == 0);
         if (br == 2'b01) e.taken = e.zero;
         if (br == 2'b10) e.taken = !e.zero;
      end
      return e;
   endfunction

   // Scoreboard: sampled at the falling edge, where inputs and outputs are
   // stable and show exactly what the next rising edge will act on.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         checkOutput("alu_sl_never_illegal", 64'(alu_sl[2]), 64'd0);
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               checkOutput("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("rsp_tag",    64'(rsp_tag),    64'(e.tag));
               checkOutput("rsp_result", 64'(rsp_result), 64'(e.result));
               checkOutput("rsp_zero",   64'(rsp_zero),   64'(e.zero));
               checkOutput("rsp_err",    64'(rsp_err),    64'(e.err));
`ifdef ALU_ISSUER_BRANCH_EN
               checkOutput("rsp_taken",  64'(rsp_taken),  64'(e.taken));
`endif
            end
         end
         if (cmd_valid && cmd_ready) begin
            sb_q.push_back(modelResponse(cmd_op, cmd_a, cmd_b, cmd_tag, cmd_br));
         end
      end
   end

   // Presents one command and holds it until accepted. Called just after a
   // rising edge; returns just after the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                                input logic [1:0] br);
      bit done = 0;
      int waited = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_tag   = tag;
      cmd_br    = br;
      while (!done && waited < 200) begin
         @(negedge clk);
         if (cmd_ready) done = 1;
         waited++;
         @(posedge clk);
         #1;
      end
      if (!done) checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      cmd_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitIdle();
      int n = 0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      while (busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) checkOutput("drain_timeout", 64'd1, 64'd0);
      idleCycles(1);
      checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic acc;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_tag   = '0;
      cmd_br    = 2'b00;
      rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_rsp_valid",  64'(rsp_valid),  64'd0);
      checkOutput("reset_busy",       64'(busy),       64'd0);
      checkOutput("reset_cmd_ready",  64'(cmd_ready),  64'd1);
      checkOutput("reset_alu_sl",     64'(alu_sl),     64'd0);
      checkOutput("reset_alu_a",      64'(alu_a),      64'd0);
      checkOutput("reset_alu_b",      64'(alu_b),      64'd0);
      checkOutput("reset_rsp_result", 64'(rsp_result), 64'd0);
      checkOutput("reset_rsp_tag",    64'(rsp_tag),    64'd0);
      rst_n = 1'b1;
      idleCycles(1);

      // Single add: latency and issue-stage contents
      $display("[TB] single add");
      rsp_ready = 1'b1;
      applyStimulus(3'b000, 32'd5, 32'd7, 4'd3, 2'b00);
      checkOutput("add_issue_alu_a",   64'(alu_a),     64'd5);
      checkOutput("add_issue_alu_b",   64'(alu_b),     64'd7);
      checkOutput("add_issue_alu_sl",  64'(alu_sl),    64'd0);
      checkOutput("add_issue_busy",    64'(busy),      64'd1);
      checkOutput("add_edge1_valid",   64'(rsp_valid), 64'd0);
      idleCycles(1);
      checkOutput("add_edge2_valid",   64'(rsp_valid),  64'd1);
      checkOutput("add_edge2_result",  64'(rsp_result), 64'd12);
      checkOutput("add_edge2_tag",     64'(rsp_tag),    64'd3);
      waitIdle();
      checkOutput("alu_a_holds_idle",  64'(alu_a),     64'd5);

      // Sub to zero and logical ops
      $display("[TB] sub and logical ops");
      applyStimulus(3'b001, 32'h10, 32'h10, 4'd4, 2'b00);
      applyStimulus(3'b010, 32'd4,  32'd0,  4'd5, 2'b00);
      applyStimulus(3'b011, 32'd4,  32'd0,  4'd6, 2'b00);
      waitIdle();

      // Illegal op never reaches the ALU
      $display("[TB] illegal op");
      applyStimulus(3'b101, 32'h1234, 32'h1, 4'hA, 2'b00);
      checkOutput("illegal_alu_sl", 64'(alu_sl), 64'd0);
      checkOutput("illegal_alu_a",  64'(alu_a),  64'h1234);
      waitIdle();

      // Backpressure: exactly four commands fit (issue slot + FIFO fill)
      $display("[TB] backpressure");
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'b000, WIDTH'(i), 32'd1, TAG_W'(i), 2'b00);
      end
      checkOutput("bp_ready_after_4", 64'(cmd_ready), 64'd0);
      cmd_valid = 1'b1;
      cmd_op    = 3'b000;
      cmd_a     = 32'd4;
      cmd_b     = 32'd1;
      cmd_tag   = 4'd4;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("bp_ready_held_low", 64'(cmd_ready), 64'd0);
      checkOutput("bp_head_tag",       64'(rsp_tag),   64'd0);
      checkOutput("bp_busy",           64'(busy),      64'd1);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_drain_tag1", 64'(rsp_tag), 64'd1);
      applyStimulus(3'b000, 32'd4, 32'd1, 4'd4, 2'b00);
      checkOutput("bp_drain_tag2", 64'(rsp_tag),   64'd2);
      checkOutput("bp_drain_valid", 64'(rsp_valid), 64'd1);
      for (int i = 5; i < 8; i++) begin
         applyStimulus(3'b000, WIDTH'(i), 32'd1, TAG_W'(i), 2'b00);
      end
      waitIdle();

`ifdef ALU_ISSUER_BRANCH_EN
      // Branch evaluation from the captured zero flag
      $display("[TB] branches");
      applyStimulus(3'b001, 32'd9, 32'd9, 4'd1, 2'b01);
      applyStimulus(3'b001, 32'd9, 32'd9, 4'd2, 2'b10);
      applyStimulus(3'b001, 32'd9, 32'd3, 4'd3, 2'b10);
      applyStimulus(3'b001, 32'd9, 32'd9, 4'd4, 2'b11);
      waitIdle();
`endif

      // Randomised traffic with random backpressure
      $display("[TB] random traffic");
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         acc = cmd_valid && cmd_ready;
         @(posedge clk);
         #1;
         if (!cmd_valid || acc) begin
            if ($urandom_range(0, 3) != 0) begin
               cmd_valid = 1'b1;
               cmd_op    = ($urandom_range(0, 7) == 0) ? {1'b1, 2'($urandom)} : {1'b0, 2'($urandom)};
               cmd_a     = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
               case ($urandom_range(0, 3))
                  0:       cmd_b = cmd_a;
                  1:       cmd_b = 32'd0;
                  default: cmd_b = 32'($urandom);
               endcase
               cmd_tag   = TAG_W'($urandom);
`ifdef ALU_ISSUER_BRANCH_EN
               cmd_br    = 2'($urandom);
`else
               cmd_br    = 2'b00;
`endif
            end else begin
               cmd_valid = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      cmd_br = 2'b00;
      waitIdle();

      // Asynchronous reset with three buffered responses
      $display("[TB] reset mid-stream");
      rsp_ready = 1'b0;
      applyStimulus(3'b000, 32'd20, 32'd1, 4'd7, 2'b00);
      applyStimulus(3'b000, 32'd21, 32'd1, 4'd8, 2'b00);
      applyStimulus(3'b000, 32'd22, 32'd1, 4'd9, 2'b00);
      idleCycles(2);
      checkOutput("pre_reset_valid", 64'(rsp_valid), 64'd1);
      checkOutput("pre_reset_tag",   64'(rsp_tag),   64'd7);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_valid",  64'(rsp_valid),  64'd0);
      checkOutput("async_reset_busy",   64'(busy),       64'd0);
      checkOutput("async_reset_result", 64'(rsp_result), 64'd0);
      checkOutput("async_reset_tag",    64'(rsp_tag),    64'd0);
      checkOutput("async_reset_ready",  64'(cmd_ready),  64'd1);
      sb_q.delete();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idleCycles(4);
      checkOutput("post_reset_valid", 64'(rsp_valid), 64'd0);
      checkOutput("post_reset_busy",  64'(busy),      64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
